// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   - parity mode constants (PAR_NONE / PAR_ODD / PAR_EVEN)
//   - transmit FSM state type
//   - baud_div(): clock cycles per bit, integer-truncated
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   function automatic int unsigned baud_div(input int unsigned clk_freq,
                                            input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO holding bytes queued for transmission.
// Ports:
//   clk, rst   clock, synchronous active-low reset (clears pointers/count)
//   i_push     write i_wdata (ignored when full)
//   i_wdata    write data
//   i_pop      advance read pointer (ignored when empty)
//   o_rdata    head entry (valid when !o_empty)
//   o_full     DEPTH entries held
//   o_empty    no entries held
//   o_count    occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Storage carries no reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
// Buffered UART transmitter. Bytes enter a FIFO through a valid/ready
// handshake and are sent as start, data (LSB first), optional parity and
// stop bits. Frames go out back-to-back while the FIFO holds data.
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-low
//   s_data      byte to transmit
//   s_valid     s_data valid
//   s_ready     FIFO can accept (== !full)
//   Tx          serial line, idles high, registered
//   busy        frame in progress or FIFO non-empty, registered
//   fifo_count  FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 100000000,
   parameter int unsigned Baud       = 9600,
   parameter int unsigned DataBits   = 8,
   parameter int unsigned StopBits   = 2,
   parameter int unsigned Parity     = 2,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DataBits-1:0]           s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic                          Tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned DIV = baud_div(CLK_FREQ, Baud);
   localparam int unsigned CW  = $clog2(DIV);

   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(DataBits - 1);
   localparam logic          STOP_LAST = 1'(StopBits - 1);

   tx_state_t               r_state;
   tx_state_t               w_state_next;
   logic [CW-1:0]           r_baud;
   logic [DataBits-1:0]     r_shift;
   logic                    r_par;
   logic [2:0]              r_bit_idx;
   logic                    r_stop_idx;
   logic                    r_tx;
   logic                    r_busy;

   logic                    w_tick;
   logic                    w_pop;
   logic                    w_tx_next;
   logic                    w_full;
   logic                    w_empty;
   logic [DataBits-1:0]     w_rdata;
   logic                    w_par_calc;

   uart_sync_fifo #(
      .WIDTH (DataBits),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (s_valid && s_ready),
      .i_wdata (s_data),
      .i_pop   (w_pop),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );

   assign s_ready    = !w_full;
   assign Tx         = r_tx;
   assign busy       = r_busy;
   assign w_tick     = (r_baud == BAUD_LAST);
   assign w_par_calc = (Parity == PAR_EVEN) ? (^w_rdata) : ~(^w_rdata);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Line level follows the current state; it is registered, so Tx trails
   // the state by one cycle uniformly and every bit still lasts DIV cycles.
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_tx_next    = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_tx_next = 1'b1;
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_state_next = ST_START;
            end
         end
         ST_START: begin
            w_tx_next = 1'b0;
            if (w_tick) begin
               w_state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            w_tx_next = r_shift[0];
            if (w_tick && (r_bit_idx == BIT_LAST)) begin
               w_state_next = (Parity == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
         end
         ST_PARITY: begin
            w_tx_next = r_par;
            if (w_tick) begin
               w_state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            w_tx_next = 1'b1;
            if (w_tick && (r_stop_idx == STOP_LAST)) begin
               // Chain straight into the next start bit when data is waiting.
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_state_next = ST_START;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_baud     <= '0;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_tx   <= w_tx_next;
         r_busy <= (r_state != ST_IDLE) || !w_empty;
         if (w_pop) begin
            r_shift    <= w_rdata;
            r_par      <= w_par_calc;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
         end else if (r_state == ST_IDLE) begin
            r_baud <= '0;
         end else begin
            r_baud <= w_tick ? '0 : r_baud + CW'(1);
            if (w_tick && (r_state == ST_DATA)) begin
               r_shift   <= r_shift >> 1;
               r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_tick && (r_state == ST_STOP)) begin
               r_stop_idx <= ~r_stop_idx;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffered
// Directed bench for uart_tx_buffered. Three instances at DIV=10:
//   unit 0: 8 data bits, even parity, 2 stop bits
//   unit 1: 8 data bits, odd parity, 2 stop bits
//   unit 2: 5 data bits, no parity, 1 stop bit
// ---------------------------------------------------------------------------
module tb_uart_tx_buffered;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] sd_a = '0;
   logic [7:0] sd_b = '0;
   logic [4:0] sd_c = '0;
   logic [2:0] vld  = '0;
   logic [2:0] txw;
   logic [2:0] busyw;
   logic [2:0] rdyw;
   logic [4:0] cnt_a;
   logic [4:0] cnt_b;
   logic [4:0] cnt_c;

   int n_tests = 0;
   int n_fail  = 0;

   // line monitor for unit 0
   logic       mon_en = 1'b0;
   logic [7:0] rx_q[$];
   int         rx_err = 0;

   always #5 clk = ~clk;

   uart_tx_buffered #(
      .CLK_FREQ (100000000), .Baud (10000000), .DataBits (8),
      .StopBits (2), .Parity (2), .FIFO_DEPTH (16)
   ) u_a (
      .clk (clk), .rst (rst), .s_data (sd_a), .s_valid (vld[0]),
      .s_ready (rdyw[0]), .Tx (txw[0]), .busy (busyw[0]), .fifo_count (cnt_a)
   );

   uart_tx_buffered #(
      .CLK_FREQ (100000000), .Baud (10000000), .DataBits (8),
      .StopBits (2), .Parity (1), .FIFO_DEPTH (16)
   ) u_b (
      .clk (clk), .rst (rst), .s_data (sd_b), .s_valid (vld[1]),
      .s_ready (rdyw[1]), .Tx (txw[1]), .busy (busyw[1]), .fifo_count (cnt_b)
   );

   uart_tx_buffered #(
      .CLK_FREQ (100000000), .Baud (10000000), .DataBits (5),
      .StopBits (1), .Parity (0), .FIFO_DEPTH (16)
   ) u_c (
      .clk (clk), .rst (rst), .s_data (sd_c), .s_valid (vld[2]),
      .s_ready (rdyw[2]), .Tx (txw[2]), .busy (busyw[2]), .fifo_count (cnt_c)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] get_cnt(input int unit);
      case (unit)
         0:       return cnt_a;
         1:       return cnt_b;
         default: return cnt_c;
      endcase
   endfunction

   task automatic drive(input int unit, input logic [7:0] data, input logic v);
      case (unit)
         0:       sd_a = data;
         1:       sd_b = data;
         default: sd_c = data[4:0];
      endcase
      vld[unit] = v;
   endtask

   // Checks one full frame on the line, starting at the current cycle
   // (first start-bit cycle) and ending on the last stop-bit cycle.
   task automatic check_frame(input int unit, input logic [7:0] data, input int nbits,
                              input int par, input int nstop, input string tag);
      logic bits [12];
      int   len;
      logic p;
      p = 1'b0;
      bits[0] = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         bits[1+i] = data[i];
         p = p ^ data[i];
      end
      len = 1 + nbits;
      if (par != 0) begin
         bits[len] = (par == 1) ? ~p : p;
         len++;
      end
      for (int s = 0; s < nstop; s++) begin
         bits[len] = 1'b1;
         len++;
      end
      for (int k = 0; k < len * 10; k++) begin
         chk($sformatf("%s line bit%0d cyc%0d", tag, k / 10, k % 10), 32'(txw[unit]), 32'(bits[k / 10]));
         if (k < len * 10 - 1) tick();
      end
   endtask

   // Push one byte into an idle unit and check latency, frame and busy.
   task automatic send_and_check(input int unit, input logic [7:0] data, input int nbits,
                                 input int par, input int nstop, input string tag);
      drive(unit, data, 1'b1);
      tick();                                     // edge N: accepted
      drive(unit, data, 1'b0);
      chk({tag, " count after push"}, 32'(get_cnt(unit)), 32'd1);
      chk({tag, " Tx idle at N"}, 32'(txw[unit]), 32'd1);
      tick();                                     // edge N+1: popped
      chk({tag, " Tx idle at N+1"}, 32'(txw[unit]), 32'd1);
      chk({tag, " busy at pop"}, 32'(busyw[unit]), 32'd1);
      chk({tag, " count after pop"}, 32'(get_cnt(unit)), 32'd0);
      tick();                                     // edge N+2: start bit
      check_frame(unit, data, nbits, par, nstop, tag);
      chk({tag, " busy in last stop cycle"}, 32'(busyw[unit]), 32'd1);
      tick();
      chk({tag, " busy after frame"}, 32'(busyw[unit]), 32'd0);
      chk({tag, " Tx after frame"}, 32'(txw[unit]), 32'd1);
   endtask

   // Mid-bit sampler for unit 0 (8 bits, even parity, 2 stops).
   always begin : monitor
      logic [7:0] d;
      logic       ok;
      tick();
      if (mon_en && txw[0] === 1'b0) begin
         ok = 1'b1;
         repeat (4) tick();
         if (txw[0] !== 1'b0) ok = 1'b0;
         for (int i = 0; i < 8; i++) begin
            repeat (10) tick();
            d[i] = txw[0];
         end
         repeat (10) tick();
         if (txw[0] !== ^d) ok = 1'b0;
         repeat (10) tick();
         if (txw[0] !== 1'b1) ok = 1'b0;
         repeat (10) tick();
         if (txw[0] !== 1'b1) ok = 1'b0;
         rx_q.push_back(d);
         if (!ok) rx_err++;
      end
   end

   initial begin : stimulus
      int         bad;
      logic [7:0] nb;
      logic       was_ready;
      logic       seen_full;

      // reset
      rst = 1'b0;
      repeat (3) tick();
      chk("reset Tx", 32'(txw[0]), 32'd1);
      chk("reset busy", 32'(busyw[0]), 32'd0);
      chk("reset s_ready", 32'(rdyw[0]), 32'd1);
      chk("reset count", 32'(cnt_a), 32'd0);
      chk("reset Tx odd unit", 32'(txw[1]), 32'd1);
      chk("reset Tx 5-bit unit", 32'(txw[2]), 32'd1);
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (txw[0] !== 1'b1 || busyw[0] !== 1'b0) bad++;
      end
      chk("idle 200 cycles", 32'(bad), 32'd0);

      // single byte, even and odd parity
      send_and_check(0, 8'hA5, 8, 2, 2, "even A5");
      send_and_check(1, 8'hA5, 8, 1, 2, "odd A5");

      // back-to-back frames
      drive(0, 8'h00, 1'b1);
      tick();                                     // N
      drive(0, 8'hFF, 1'b1);
      tick();                                     // N+1
      drive(0, 8'h55, 1'b1);
      tick();                                     // N+2
      drive(0, 8'h55, 1'b0);
      chk("b2b count", 32'(cnt_a), 32'd2);
      check_frame(0, 8'h00, 8, 2, 2, "b2b 00");
      tick();
      check_frame(0, 8'hFF, 8, 2, 2, "b2b FF");
      tick();
      check_frame(0, 8'h55, 8, 2, 2, "b2b 55");
      chk("b2b busy last stop", 32'(busyw[0]), 32'd1);
      tick();
      chk("b2b busy after", 32'(busyw[0]), 32'd0);

      // full FIFO with a holding sender
      rx_q.delete();
      rx_err = 0;
      mon_en = 1'b1;
      nb = 8'h00;
      seen_full = 1'b0;
      for (int i = 0; i < 20; i++) begin
         drive(0, nb, 1'b1);
         was_ready = rdyw[0];
         tick();
         if (was_ready) nb = nb + 8'd1;
         if (!rdyw[0] && !seen_full) begin
            seen_full = 1'b1;
            chk("count when s_ready falls", 32'(cnt_a), 32'd16);
         end
      end
      drive(0, nb, 1'b0);
      chk("full seen", 32'(seen_full), 32'd1);
      chk("bytes accepted", 32'(nb), 32'h11);
      chk("full s_ready", 32'(rdyw[0]), 32'd0);
      chk("full count", 32'(cnt_a), 32'd16);
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (busyw[0] === 1'b0) break;
      end
      chk("drain within bound", 32'(busyw[0]), 32'd0);
      mon_en = 1'b0;
      chk("rx frame count", 32'(rx_q.size()), 32'd17);
      for (int i = 0; i < 17; i++) begin
         if (i < rx_q.size()) chk($sformatf("rx byte %0d", i), 32'(rx_q[i]), 32'(i));
      end
      chk("rx framing errors", 32'(rx_err), 32'd0);

      // reset mid-frame
      drive(0, 8'h00, 1'b1);
      tick();                                     // N
      drive(0, 8'h12, 1'b1);
      tick();
      drive(0, 8'h34, 1'b1);
      tick();                                     // N+2
      drive(0, 8'h34, 1'b0);
      repeat (30) tick();                         // N+32: data bit 2
      chk("pre-reset Tx in data", 32'(txw[0]), 32'd0);
      chk("pre-reset count", 32'(cnt_a), 32'd2);
      rst = 1'b0;
      tick();
      chk("mid reset Tx", 32'(txw[0]), 32'd1);
      chk("mid reset count", 32'(cnt_a), 32'd0);
      chk("mid reset busy", 32'(busyw[0]), 32'd0);
      chk("mid reset s_ready", 32'(rdyw[0]), 32'd1);
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (txw[0] !== 1'b1 || busyw[0] !== 1'b0) bad++;
      end
      chk("silent after reset", 32'(bad), 32'd0);

      // 5 data bits, no parity, 1 stop bit
      send_and_check(2, 8'h1F, 5, 0, 1, "5N1 1F");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered UART transmitter: the transmitting end for the team's parity-checking UART receiver.
- Accepts bytes through a valid/ready handshake into an internal FIFO.
- Serialises each byte as start, data LSB-first, optional parity, then stop bits.
- Sends frames back-to-back with no idle gap while the FIFO holds data; intended to replace the unbuffered transmitter path in full-duplex builds.

Parameters:
- CLK_FREQ, 100000000: clock frequency in Hz.
- Baud, 9600: line rate. Bit period DIV = CLK_FREQ/Baud clock cycles, integer truncation (10416 at defaults). Legal only when DIV >= 4.
- DataBits, 8: data bits per frame. Legal values 5..8.
- StopBits, 2: stop bits per frame. Legal values 1 or 2.
- Parity, 2: 0 = none, 1 = odd, 2 = even.
- FIFO_DEPTH, 16: FIFO entries. Must be a power of two, >= 2.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous reset, active-low.
- s_data  in  DataBits  byte to transmit.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  FIFO can accept a byte; equals !full.
- Tx  out  1  serial line; idles high.
- busy  out  1  high when a frame is in progress or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: applied on a clk edge with rst=0.
  - Outputs: Tx=1, busy=0, fifo_count=0, s_ready=1.
  - FSM goes to IDLE; FIFO pointers clear; the baud counter clears.
- Push: a byte is written on a clk edge where s_valid && s_ready. fifo_count increments on that edge.
- Full FIFO: s_ready=0. The sender must hold s_data until accepted; nothing is lost or overwritten.
- Pop and push in the same cycle are allowed. fifo_count is then unchanged.
- FSM states and transitions:
  - IDLE: Tx=1. If the FIFO is non-empty, pop the head into a shift register, compute parity, clear the baud counter, go to START.
  - START: Tx=0 for DIV cycles, then go to DATA.
  - DATA: Tx=shift[0] for DIV cycles per bit. Shift right after each bit. After DataBits bits, go to PARITY, or to STOP if Parity=0.
  - PARITY: Tx = XOR of the data bits (even), or its inverse (odd), for DIV cycles. Then go to STOP.
  - STOP: Tx=1 for StopBits*DIV cycles.
    - At the end, if the FIFO is non-empty, pop the next byte in that same cycle and go directly to START, so the next start bit follows the last stop cycle with no gap.
    - Otherwise go to IDLE.
- Latency from an empty, idle block:
  - Byte accepted at edge N.
  - FIFO non-empty after N; pop at edge N+1.
  - Tx falls at edge N+2.
- Baud counter: counts 0..DIV-1, rolls over, and advances the bit on the terminal count. Every bit lasts exactly DIV cycles.
- Frame length: (1 + DataBits + (Parity!=0) + StopBits) * DIV cycles. At defaults this is 12*10416 = 124992.
- busy: asserted from the pop cycle until the last stop-bit cycle completes with the FIFO empty, then deasserted together with the return to IDLE.
- Reset mid-frame: Tx=1 on the next edge and the frame is abandoned. FIFO contents are discarded.
- s_data changes while s_valid=0 have no effect.
- Tx is a registered output with no combinational path from the inputs.

Decomposition:
- Package uart_pkg holds:
  - parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP);
  - function baud_div(CLK_FREQ, Baud).
- Sub-module uart_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count) holds the buffer.
- The transmit FSM and baud counter stay in uart_tx_buffered.

Test Plan:
- Use CLK_FREQ=100000000, Baud=10000000 (DIV=10), DataBits=8, Parity=2, StopBits=2 unless noted.
- Reset: hold rst=0 for 3 cycles, then release -> Tx=1, busy=0, s_ready=1, fifo_count=0; Tx stays 1 for 200 idle cycles.
- Single byte: push 0xA5 at edge N -> Tx falls at N+2.
  - Line pattern in 10-cycle bits: 0, 1,0,1,0,0,1,0,1, parity 0, then 1,1.
  - busy drops 120 cycles after N+2.
  - Repeat with Parity=1 -> parity bit 1.
- Back-to-back: push 0x00, 0xFF, 0x55 in consecutive cycles -> three 120-cycle frames with no idle cycle between them; the start bit follows the last stop cycle directly.
- Full FIFO: hold s_valid=1 for 20 cycles with an incrementing byte starting at 0x00.
  - s_ready falls when fifo_count=16.
  - Bytes 0x00-0x10 are accepted: one is popped at once, then 16 fill the FIFO.
  - Received sequence decodes in order with none lost.
- Reset mid-frame: with 3 bytes queued, pull rst=0 during the DATA state of the first frame -> Tx=1 on the next edge, fifo_count=0, busy=0; no further frames are sent.
- Config sweep: DataBits=5, Parity=0, StopBits=1; push 0x1F -> frame is 0, 1,1,1,1,1, then 1, totalling 70 cycles.
